// File: rtl/run_detect_pkg.sv
// run_detect_pkg: shared state encoding and default parameters for run_detect_gen
package run_detect_pkg;
  localparam int DW_DEF = 12;
  localparam int RUN_LEN_DEF = 4;
  localparam int CW_DEF = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ARMED  = 3'b010,
    IN_RUN = 3'b100
  } state_t;
endpackage

// File: rtl/run_detect_gen_if.sv
// run_detect_gen_if: sample/control inputs and result outputs of run_detect_gen
// master drives sig, sig_vld, strt_cap_cmp, stop, cmp_below; slave returns thr, n_runs, run_det, in_run, armed
interface run_detect_gen_if import run_detect_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  logic [DW-1:0] sig;
  logic          sig_vld;
  logic          strt_cap_cmp;
  logic          stop;
  logic          cmp_below;
  logic [DW-1:0] thr;
  logic [CW-1:0] n_runs;
  logic          run_det;
  logic          in_run;
  logic          armed;
  modport master (
    output sig, sig_vld, strt_cap_cmp, stop, cmp_below,
    input  thr, n_runs, run_det, in_run, armed
  );
  modport slave (
    input  sig, sig_vld, strt_cap_cmp, stop, cmp_below,
    output thr, n_runs, run_det, in_run, armed
  );
endinterface

// File: rtl/run_detect_gen_sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear
// clk, rst (async, active-high), clr (priority over inc), inc, cnt (holds at all-ones)
module sat_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/run_detect_gen.sv
// run_detect_gen: counts runs of RUN_LEN valid samples strictly above/below a captured threshold
// clk, rst (async, active-high), bus: sig/sig_vld/strt_cap_cmp/stop/cmp_below in, thr/n_runs/run_det/in_run/armed out
module run_detect_gen import run_detect_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CW = CW_DEF
) (
  input logic clk,
  input logic rst,
  run_detect_gen_if.slave bus
);
  localparam int CNT_W = $clog2(RUN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);
  state_t           state;
  logic [DW-1:0]    thr_q;
  logic [CNT_W-1:0] run_cnt;
  logic             mode_q;
  logic             qual;
  logic             hit;
  assign qual = mode_q ? bus.sig < thr_q : bus.sig > thr_q;
  // the sample that completes a run; strt/stop in the same cycle pre-empt it
  assign hit = !bus.strt_cap_cmp && !bus.stop && state == ARMED && bus.sig_vld && qual && run_cnt == LAST;
  assign bus.thr = thr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      thr_q <= '0;
      mode_q <= 1'b0;
      run_cnt <= '0;
      bus.run_det <= 1'b0;
      bus.in_run <= 1'b0;
      bus.armed <= 1'b0;
    end else begin
      bus.run_det <= 1'b0;
      if (bus.strt_cap_cmp) begin
        thr_q <= bus.sig;
        mode_q <= bus.cmp_below;
        run_cnt <= '0;
        state <= ARMED;
        bus.armed <= 1'b1;
        bus.in_run <= 1'b0;
      end else if (bus.stop) begin
        run_cnt <= '0;
        state <= IDLE;
        bus.armed <= 1'b0;
        bus.in_run <= 1'b0;
      end else case (state)
        IDLE: ;
        ARMED: if (bus.sig_vld) begin
          run_cnt <= (qual && run_cnt != LAST) ? run_cnt + 1'b1 : '0;
          if (hit) begin
            state <= IN_RUN;
            bus.in_run <= 1'b1;
            bus.run_det <= 1'b1;
          end
        end
        IN_RUN: if (bus.sig_vld && !qual) begin
          state <= ARMED;
          bus.in_run <= 1'b0;
        end
        default: begin
          state <= IDLE;
          run_cnt <= '0;
          bus.armed <= 1'b0;
          bus.in_run <= 1'b0;
        end
      endcase
    end
  sat_cnt #(.CW(CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(bus.strt_cap_cmp),
    .inc(hit),
    .cnt(bus.n_runs)
  );
endmodule

// File: doc/run_detect_gen.md
RUN_DETECT_GEN -- requirements
Module: run_detect_gen

Interface
REQ-001 The block SHALL take parameter DW, default 12, as the width of sig and threshold.
REQ-002 The block SHALL take parameter RUN_LEN, default 4, as the qualifying run length, legal range 2..255.
REQ-003 The block SHALL take parameter CW, default 8, as the width of the n_runs counter.
REQ-004 clk  input  1  system clock; all flops rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sig  input  DW  sample value, unsigned.
REQ-007 sig_vld  input  1  sig valid this cycle.
REQ-008 strt_cap_cmp  input  1  capture sig as threshold, clear counts, arm.
REQ-009 stop  input  1  disarm, hold results.
REQ-010 cmp_below  input  1  mode select: 0 = qualify sig > thr; 1 = qualify sig < thr.
REQ-011 thr  output  DW  captured threshold.
REQ-012 n_runs  output  CW  count of qualifying runs detected.
REQ-013 run_det  output  1  one-cycle pulse per detected run.
REQ-014 in_run  output  1  high while in IN_RUN.
REQ-015 armed  output  1  high in ARMED or IN_RUN.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED and IN_RUN.
REQ-017 strt_cap_cmp in any state SHALL, at the next edge: load thr<=sig and mode_q<=cmp_below; clear run_cnt and n_runs; enter ARMED.
REQ-018 The sample present in the strt_cap_cmp cycle SHALL be used only as threshold and SHALL NOT be compared.
REQ-019 strt_cap_cmp SHALL take priority over stop; stop alone SHALL enter IDLE, clear run_cnt and hold thr and n_runs.
REQ-020 Qualify SHALL be (mode_q ? sig<thr : sig>thr), strictly; equality never qualifies.
REQ-021 cmp_below changes after capture SHALL have no effect.
REQ-022 Cycles with sig_vld=0 SHALL leave state and run_cnt unchanged (gaps do not break a run).
REQ-023 ARMED with a valid qualifying sample and run_cnt<RUN_LEN-1 SHALL increment run_cnt.
REQ-024 ARMED with a valid qualifying sample and run_cnt==RUN_LEN-1 SHALL: increment n_runs; pulse run_det on the following cycle; clear run_cnt; enter IN_RUN.
REQ-025 ARMED with a valid non-qualifying sample SHALL clear run_cnt.
REQ-026 IN_RUN SHALL stay while valid samples qualify (no further counting) and SHALL return to ARMED with run_cnt=0 on a valid non-qualifying sample.
REQ-027 n_runs SHALL saturate at 2^CW-1; run_det SHALL still pulse at saturation.
REQ-028 IDLE SHALL ignore sig and sig_vld.
REQ-029 run_cnt width SHALL be $clog2(RUN_LEN).
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst SHALL asynchronously force: IDLE; thr=0; n_runs=0; run_cnt=0; mode_q=0; run_det=0; in_run=0; armed=0.
REQ-032 rst mid-run SHALL discard the partial run; no run_det pulse after rst deasserts.
REQ-033 The state register SHALL use an illegal-state default that returns to IDLE.

Structure
REQ-034 Package run_detect_pkg SHALL hold the state_t enum (one-hot, 3 bits) and the default parameter constants.
REQ-035 The saturating n_runs counter SHALL be a sub-module sat_cnt (params CW; ports clk, rst, clr, inc, cnt).

Verification
REQ-036 Capture and count: strt with sig=100, then valid 101,150,200,120 -> n_runs=1, one run_det pulse, in_run=1.
REQ-037 Run break: thr=100, valid 101,102,100,101,102,103,104 -> the equal sample breaks the run; n_runs=1 after the 7th sample; no count before it.
REQ-038 Long run and gaps: thr=100, 9 qualifying samples with sig_vld low every other cycle -> n_runs=1; then 50 followed by 4x 200 -> n_runs=2.
REQ-039 Below mode: cmp_below=1, strt with sig=500, then 4x 10, toggle cmp_below, 4x 600 -> n_runs=1.
REQ-040 Saturation and priority: CW=2, 5 runs -> n_runs=3 with 5 run_det pulses; strt and stop together -> ARMED and n_runs=0; stop alone -> IDLE, n_runs held.
REQ-041 Async reset: assert rst after 3 of 4 qualifying samples -> all outputs 0 immediately; no run_det after release.
